// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply / divide unit for the execute stage.
//
// Multiplies by shift-add (2*WIDTH product) and divides by restoring division
// (quotient + remainder). Each operation takes WIDTH iterations, one per cycle.
// A start/busy/done handshake lets control stall the pipeline while a result
// is in flight.
//
// Ports:
//   clk        rising-edge clock
//   rstN       asynchronous active-low reset
//   start      request, sampled only while idle
//   op         0 = MUL, 1 = DIV (unsigned), sampled with start
//   a, b       multiplicand/dividend, multiplier/divisor
//   busy       high while an operation is running or completing
//   done       one-cycle pulse, results valid
//   result     MUL: product low half;  DIV: quotient
//   resultExt  MUL: product high half; DIV: remainder
//   divByZero  last DIV had a zero divisor
//   zeroFlag   {resultExt, result} == 0 for the last completed operation
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultExt,
  output logic             divByZero,
  output logic             zeroFlag
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  // Multiplicand for MUL, divisor for DIV.
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  // MUL: {product high, multiplier/product low}; DIV: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_ext_q, result_ext_d;
  logic                 div_by_zero_q, div_by_zero_d;
  logic                 zero_q, zero_d;

  // One shift-add multiply step; carry-out of the WIDTH+1-bit adder shifts into the top.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // One restoring divide step: shift the next dividend bit into the remainder, trial
  // subtract. A negative difference means the remainder was below the divisor, so the
  // shifted value still fits in WIDTH bits when restored.
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0]   iter_acc;
  assign iter_acc = op_q ? div_next : mul_next;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    opnd_d        = opnd_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    result_ext_d  = result_ext_q;
    div_by_zero_d = div_by_zero_q;
    zero_d        = zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d          = op;
          opnd_d        = op ? b : a;
          acc_d         = {{WIDTH{1'b0}}, (op ? a : b)};
          cnt_d         = '0;
          div_by_zero_d = 1'b0;
          if (op && (b == '0)) begin
            // Divide by zero skips the iterations entirely.
            result_d      = '1;
            result_ext_d  = a;
            div_by_zero_d = 1'b1;
            zero_d        = 1'b0;
            state_d       = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          result_d     = iter_acc[WIDTH-1:0];
          result_ext_d = iter_acc[2*WIDTH-1:WIDTH];
          zero_d       = (iter_acc == '0);
          state_d      = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= StIdle;
      op_q          <= 1'b0;
      opnd_q        <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      result_ext_q  <= '0;
      div_by_zero_q <= 1'b0;
      zero_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      opnd_q        <= opnd_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      result_ext_q  <= result_ext_d;
      div_by_zero_q <= div_by_zero_d;
      zero_q        <= zero_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign resultExt = result_ext_q;
  assign divByZero = div_by_zero_q;
  assign zeroFlag  = zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes the expected response and
// the cycle its done pulse is due; a monitor pops and compares on every done.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, divByZero, zeroFlag;
  logic [W-1:0]  result, resultExt;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .resultExt (resultExt),
    .divByZero (divByZero),
    .zeroFlag  (zeroFlag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] ext;
    logic         dbz;
    logic         zf;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare on done, otherwise the held outputs must not move.
  exp_t snap = '{res: '0, ext: '0, dbz: 1'b0, zf: 1'b1, cyc: 0};
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rstN) begin
        snap = '{res: '0, ext: '0, dbz: 1'b0, zf: 1'b1, cyc: 0};
      end else if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", W'(cyc), W'(e.cyc));
          check("result", result, e.res);
          check("resultExt", resultExt, e.ext);
          check("divByZero", W'(divByZero), W'(e.dbz));
          check("zeroFlag", W'(zeroFlag), W'(e.zf));
          snap = e;
        end
      end else begin
        check("hold", {result ^ snap.res} | {resultExt ^ snap.ext} | W'(zeroFlag ^ snap.zf), '0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", W'(busy), '0);
  endtask

  // Issue one op from idle; expected done is 32 edges after accept (0 for divide by zero).
  task automatic issue(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic [W-1:0] ee, input logic ed,
                       input logic ez, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    e = '{res: er, ext: ee, dbz: ed, zf: ez, cyc: cyc + (ed ? 0 : W)};
    if (push) exp_q.push_back(e);
    check("busy_after_accept", W'(busy), W'(1'b1));
    @(negedge clk);
    start = 1'b0;
    a = 32'hA5A5_5A5A;
    b = 32'h0000_0003;
  endtask

  initial begin
    logic          t_op[4];
    logic [W-1:0]  t_a[4], t_b[4], t_r[4], t_e[4];
    exp_t e;

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_result", result, '0);
    check("rst_resultExt", resultExt, '0);
    check("rst_divByZero", W'(divByZero), '0);
    check("rst_zeroFlag", W'(zeroFlag), W'(1'b1));
    @(negedge clk);
    rstN = 1'b1;

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(1'b1, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    check("dbz_cleared", W'(divByZero), '0);

    // Abort MUL 6x7 with reset at iteration 15: outputs go to reset values, no done.
    issue(1'b0, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_result", result, '0);
    check("abort_resultExt", resultExt, '0);
    check("abort_zeroFlag", W'(zeroFlag), W'(1'b1));
    @(negedge clk);
    rstN = 1'b1;
    repeat (40) @(negedge clk);
    issue(1'b1, 32'd42, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // A start pulse mid-operation must be ignored.
    issue(1'b0, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1;
    op = 1'b1;
    a = 32'd50;
    b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // start tied high: accepts exactly W+2 cycles apart.
    t_op = '{1'b0, 1'b1, 1'b0, 1'b1};
    t_a  = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'd7};
    t_b  = '{32'h0001_0000, 32'h0000_0010, 32'd2, 32'd7};
    t_r  = '{32'h0000_0000, 32'h0FFF_FFFF, 32'h2468_ACF0, 32'd1};
    t_e  = '{32'h0000_0001, 32'h0000_000F, 32'h0000_0000, 32'd0};
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = t_op[i];
      a = t_a[i];
      b = t_b[i];
      @(posedge clk);
      #1;
      e = '{res: t_r[i], ext: t_e[i], dbz: 1'b0, zf: 1'b0, cyc: cyc + W};
      exp_q.push_back(e);
      if (i == 3) start = 1'b0;
      a = ~t_a[i];
      b = 32'd1;
      repeat (W + 1) @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("scoreboard_empty", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multi-cycle unsigned multiply/divide unit for the execute stage, sitting beside the combinational ALU and sharing its operand buses. It multiplies by shift-add, producing a 2×WIDTH product, and divides by restoring division, producing quotient and remainder. Results return on the same `result`/`resultExt` split the datapath already uses for wide results. A start/busy/done handshake lets the control unit stall the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32, operand and result half-width in bits; iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `rstN`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = MUL, 1 = DIV (unsigned); sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend.
- `b`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results valid.
- `result`  out  WIDTH  MUL: product low half; DIV: quotient.
- `resultExt`  out  WIDTH  MUL: product high half; DIV: remainder.
- `divByZero`  out  1  registered flag; set by DIV with `b == 0`.
- `zeroFlag`  out  1  `{resultExt, result} == 0` for the last completed op.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with `start` = 1:
  - Latch `a`, `b`, `op`; clear the iteration counter and accumulator.
  - Clear `divByZero`.
  - Go to RUN, except DIV with `b == 0`, which goes straight to DONE.
- IDLE with `start` = 0: hold all outputs.
- MUL, one iteration per RUN cycle:
  - If multiplier LSB = 1, add the multiplicand to the accumulator high half, capturing the carry-out as bit 2·WIDTH.
  - Shift {carry, acc} right 1.
  - Adder is WIDTH+1 bits; no overflow is possible; the full 2·WIDTH product is exact.
- DIV, one iteration per RUN cycle:
  - Shift {rem, quo} left 1 with dividend bits entering.
  - Trial-subtract the divisor from the WIDTH+1-bit remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
- RUN → DONE when the counter reaches `WIDTH`-1 at an edge, i.e. after exactly `WIDTH` iterations. `result`/`resultExt` are written on that edge.
- Divide by zero: `result` = all ones, `resultExt` = `a`, `divByZero` = 1.
- DONE → IDLE unconditionally on the next edge.
- `result`, `resultExt`, `zeroFlag` and `divByZero` hold until the next accepted `start`. They are not cleared by the DONE→IDLE transition.
- `start` while `busy` = 1 is ignored; it is not queued.
- Operand changes on `a`/`b` after acceptance have no effect.

## Timing
- Reset (`rstN` low, asynchronous): state IDLE.
  - `busy`, `done`, `divByZero`: 0.
  - `result`, `resultExt`: 0.
  - `zeroFlag`: 1, consistent with the zero result.
- Reset asserted mid-operation aborts immediately; no `done` pulse follows.
- Accepting edge E0 (IDLE, `start` = 1):
  - `busy` rises after E0.
  - Iterations occur on E1..E`WIDTH`.
  - DONE is entered after E`WIDTH`; `done` = 1 during cycle `WIDTH`+1.
  - IDLE after E`WIDTH`+1.
  - Total: `WIDTH`+2 cycles from accept to the next possible accept. For `WIDTH` = 32: `done` high 32 cycles after E0, next `start` accepted at E34.
- Divide by zero: DONE after E0; `done` high in the cycle immediately following E0; IDLE after E1.
- `done` and `busy` are registered (state-decoded from flops); no combinational path from inputs to outputs.
- `start` held high continuously: operations issue back-to-back, one accept per `WIDTH`+2 cycles.

## Test plan
- MUL 0xFFFF_FFFF × 0xFFFF_FFFF -> after 32 iterations `done` pulses once; `resultExt` = 0xFFFF_FFFE, `result` = 0x0000_0001, `zeroFlag` = 0.
- DIV 100 / 7 -> `result` = 14, `resultExt` = 2, `divByZero` = 0. Also DIV 5 / 9 -> `result` = 0, `resultExt` = 5.
- DIV 0x1234 / 0 -> `done` in the cycle after accept; `result` = 0xFFFF_FFFF, `resultExt` = 0x1234, `divByZero` = 1. A following MUL 3×4 clears the flag: `result` = 12.
- MUL 0 × 0xDEAD_BEEF -> `result` = `resultExt` = 0, `zeroFlag` = 1. Pulse `start` again with DIV at cycle 10 of the op -> ignored; exactly one `done` occurs.
- Start MUL 6×7, drop `rstN` at iteration 15 for one cycle -> all outputs return to reset values at once, no `done`. After release, DIV 42 / 6 -> `result` = 7, `resultExt` = 0.
- `start` tied high with alternating ops -> accepts spaced exactly 34 cycles apart, each `done` is 1 cycle wide, and outputs are stable between `done` pulses.
